// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment rule used to flag misaligned accesses.
package lsu_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } size_e;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    function automatic logic is_misaligned(size_e size, logic [1:0] off);
        case (size)
            HALF:    return off[0];
            WORD:    return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational lane logic: extracts/extends a sub-word from a memory word and
// merges a right-justified sub-word into an old word (little-endian lanes).
module lsu_byte_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        sgn,
    input  logic [31:0] new_data,
    output logic [31:0] ext,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] mask;
    logic [31:0] repl;

    always_comb begin
        byte_v = word[{off, 3'b000} +: 8];
        half_v = word[{off[1], 4'b0000} +: 16];
        case (size)
            BYTE:    ext = {{24{sgn & byte_v[7]}}, byte_v};
            HALF:    ext = {{16{sgn & half_v[15]}}, half_v};
            default: ext = word;
        endcase
    end

    // Replicate the new data across all lanes, then keep only the target lanes.
    always_comb begin
        case (size)
            BYTE: begin
                mask = 32'h0000_00FF << {off, 3'b000};
                repl = {4{new_data[7:0]}};
            end
            HALF: begin
                mask = 32'h0000_FFFF << {off[1], 4'b0000};
                repl = {2{new_data[15:0]}};
            end
            default: begin
                mask = '1;
                repl = new_data;
            end
        endcase
        merged = (word & ~mask) | (repl & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit with 2-cycle read-modify-write for sub-word stores.
// Optional feature macro: LSU_BOUNDS_CHECK_EN (range-check word index against NUM_WORDS).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int NUM_WORDS = 256,
    parameter int DW        = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          ld_valid,
    output logic [DW-1:0] ld_data,
    output logic          exc_valid,
    output logic [31:0]   exc_addr,
    output logic [31:0]   DMA,
    output logic          DMWE,
    output logic          DMRD,
    output logic [DW-1:0] DMWD,
    input  logic [DW-1:0] DMOut
);

`ifdef LSU_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif
    localparam logic [29:0] WORD_LIMIT = 30'(NUM_WORDS);

    state_e      state_q, state_d;
    logic [31:0] old_q, old_d;
    logic [31:0] addr_q, addr_d;
    size_e       size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic        ld_valid_q, ld_valid_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        exc_valid_q, exc_valid_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    size_e       req_sz;
    logic        fault;
    logic        dm_we, dm_rd;
    logic [31:0] lane_word, lane_ext, lane_merged;
    logic [1:0]  lane_off;
    size_e       lane_size;

    always_comb begin
        req_sz = (req_size == 2'd3) ? WORD : size_e'(req_size);
        fault  = is_misaligned(req_sz, req_addr[1:0])
               | (BOUNDS_EN & (req_addr[31:2] >= WORD_LIMIT));
    end

    // One lane instance serves both phases: extraction in IDLE, merge in MERGE.
    always_comb begin
        lane_word = (state_q == MERGE) ? old_q        : DMOut;
        lane_off  = (state_q == MERGE) ? addr_q[1:0]  : req_addr[1:0];
        lane_size = (state_q == MERGE) ? size_q       : req_sz;
    end

    lsu_byte_lane u_lane (
        .word     (lane_word),
        .off      (lane_off),
        .size     (lane_size),
        .sgn      (req_signed),
        .new_data (wdata_q),
        .ext      (lane_ext),
        .merged   (lane_merged)
    );

    always_comb begin
        state_d     = state_q;
        old_d       = old_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        ld_valid_d  = 1'b0;
        ld_data_d   = ld_data_q;
        exc_valid_d = 1'b0;
        exc_addr_d  = exc_addr_q;
        dm_we       = 1'b0;
        dm_rd       = 1'b0;
        DMA         = {2'b00, req_addr[31:2]};
        DMWD        = req_wdata;
        req_ready   = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (fault) begin
                        exc_valid_d = 1'b1;
                        exc_addr_d  = req_addr;
                    end else if (!req_we) begin
                        dm_rd      = 1'b1;
                        ld_valid_d = 1'b1;
                        ld_data_d  = lane_ext;
                    end else if (req_sz == WORD) begin
                        dm_we = 1'b1;
                    end else begin
                        dm_rd   = 1'b1;
                        old_d   = DMOut;
                        addr_d  = req_addr;
                        size_d  = req_sz;
                        wdata_d = req_wdata;
                        state_d = MERGE;
                    end
                end
            end
            MERGE: begin
                dm_we   = 1'b1;
                DMA     = {2'b00, addr_q[31:2]};
                DMWD    = lane_merged;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign DMWE      = dm_we & ~rst;
    assign DMRD      = dm_rd & ~rst;
    assign ld_valid  = ld_valid_q;
    assign ld_data   = ld_data_q;
    assign exc_valid = exc_valid_q;
    assign exc_addr  = exc_addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            old_q       <= '0;
            addr_q      <= '0;
            size_q      <= BYTE;
            wdata_q     <= '0;
            ld_valid_q  <= 1'b0;
            ld_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            old_q       <= old_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            ld_valid_q  <= ld_valid_d;
            ld_data_q   <= ld_data_d;
            exc_valid_q <= exc_valid_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-addressed reference memory model,
// directed cases plus randomized traffic, monitor checks load/exception pulses.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        ld_valid, exc_valid;
    logic [31:0] ld_data, exc_addr;
    logic [31:0] DMA, DMWD, DMOut;
    logic        DMWE, DMRD;

    always #5 clk = ~clk;

    load_store_unit #(.NUM_WORDS(256), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .ld_valid(ld_valid), .ld_data(ld_data),
        .exc_valid(exc_valid), .exc_addr(exc_addr),
        .DMA(DMA), .DMWE(DMWE), .DMRD(DMRD), .DMWD(DMWD), .DMOut(DMOut)
    );

    // Word-wide data memory seen by the DUT
    logic [31:0] mem [0:255];
    assign DMOut = DMRD ? mem[DMA[7:0]] : 32'h0;
    always @(posedge clk) if (DMWE) mem[DMA[7:0]] <= DMWD;

    // Reference: plain byte array, 1 KiB, little-endian
    logic [7:0] ref_bytes [0:1023];

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    typedef struct {
        bit          is_exc;
        logic [31:0] val;
        int          due;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_fault(input logic [31:0] a, input logic [1:0] sz);
        return ((a % nbytes(sz)) != 0) || (BOUNDS && ((a / 4) >= 256));
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) v = v | (32'(ref_bytes[idx * 4 + i]) << (8 * i));
        return v;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        int base = int'(a % 1024);
        int n = nbytes(sz);
        logic [31:0] v = 0;
        logic [31:0] lowmask;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        if (n < 4) begin
            lowmask = (32'd1 << (8 * n)) - 32'd1;
            if (sg && v[8 * n - 1]) v = v | ~lowmask;
        end
        return v;
    endfunction

    // Present a request, wait (bounded) for acceptance, update the model.
    task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit lose_store, output logic [31:0] dma_seen);
        bit ok = 0;
        bit flt;
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        for (int w = 0; w < 10; w++) begin
            #1;
            if (req_ready) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        dma_seen = DMA;
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        flt = model_fault(a, sz);
        if (flt) check("fault_no_mem_en", {30'd0, DMWE, DMRD}, 32'd0);
        if (flt) exp_q.push_back('{is_exc: 1'b1, val: a, due: cyc + 1});
        else if (!we) exp_q.push_back('{is_exc: 1'b0, val: model_load(a, sz, sg), due: cyc + 1});
        else if (!lose_store) begin
            for (int i = 0; i < nbytes(sz); i++)
                ref_bytes[int'(a % 1024) + i] = wd[8 * i +: 8];
        end
        @(posedge clk); @(negedge clk); #1;
        req_valid = 0;
        check("ready_after", {31'd0, req_ready},
              {31'd0, !(we && !flt && nbytes(sz) < 4)});
    endtask

    task automatic idle(input int n);
        req_valid = 0;
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Monitor: every output pulse must match the oldest expectation, on time
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (ld_valid || exc_valid)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, ld_valid, exc_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, ld_valid, exc_valid}, e.is_exc ? 32'd1 : 32'd2);
                check(e.is_exc ? "exc_addr" : "ld_data", e.is_exc ? exc_addr : ld_data, e.val);
                check("pulse_latency", cyc, e.due);
            end
        end
    end

    initial begin
        logic [31:0] dma;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        for (int i = 0; i < 1024; i++) ref_bytes[i] = 8'h0;
        rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_signed = 0;
        req_addr = 0; req_wdata = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_outputs", {ld_valid, exc_valid, DMWE, DMRD, req_ready}, 32'd1);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_exc_addr", exc_addr, 32'd0);
        rst = 0;
        idle(1);

        // Word store then load
        issue(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, dma);
        issue(0, 2'd2, 0, 32'h10, 32'h0, 0, dma);
        // Byte store RMW, then signed / unsigned byte loads
        issue(1, 2'd0, 0, 32'h11, 32'h000000AA, 0, dma);
        issue(0, 2'd0, 1, 32'h11, 32'h0, 0, dma);
        check("mem4_after_sb", mem[4], 32'hDEADAAEF);
        issue(0, 2'd0, 0, 32'h11, 32'h0, 0, dma);
        // Half store, load back immediately
        issue(1, 2'd1, 0, 32'h12, 32'h00001234, 0, dma);
        issue(0, 2'd1, 0, 32'h12, 32'h0, 0, dma);
        check("mem4_after_sh", mem[4], 32'h1234AAEF);
        // Misaligned accesses
        issue(0, 2'd2, 0, 32'h13, 32'h0, 0, dma);
        issue(1, 2'd1, 0, 32'h21, 32'h5555, 0, dma);
        check("mem8_untouched", mem[8], 32'h0);
        idle(3);
        check("sb_drained", exp_q.size(), 32'd0);

        // Reset during MERGE aborts the write
        issue(1, 2'd0, 0, 32'h10, 32'h00000077, 1, dma);
        rst = 1;
        #1;
        check("rst_merge_dmwe", {31'd0, DMWE}, 32'd0);
        check("rst_merge_ready", {31'd0, req_ready}, 32'd1);
        check("rst_merge_ld_data", ld_data, 32'd0);
        check("rst_merge_exc_addr", exc_addr, 32'd0);
        @(negedge clk); #1;
        rst = 0;
        idle(1);
        check("rst_merge_mem4", mem[4], 32'h1234AAEF);

        // Out-of-range word load
        issue(0, 2'd2, 0, 32'h400, 32'h0, 0, dma);
        if (!BOUNDS) check("wrap_dma", dma, 32'h100);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            sz = 2'($urandom_range(0, 3));
            a  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 0, dma);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);
        check("queue_drained", exp_q.size(), 32'd0);
        for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_word(i));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
